// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller for the RISC-PC datapath, with
// memory wait states, timeout/illegal-opcode halting and a retired-instruction count.
module multicycle_sequencer #(
  parameter int MEM_TO = 15,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [3:0]       opcode,
  input  logic             imem_rdy,
  input  logic             dmem_rdy,
  output logic             imem_req,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             EnRW,
  output logic             ALUsrc,
  output logic [2:0]       ALUctrl,
  output logic             MReg,
  output logic             MR,
  output logic             MW,
  output logic             busy,
  output logic             halted,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_LW   = 4'b0001;
  localparam logic [3:0] OP_SW   = 4'b0010;
  localparam logic [3:0] OP_SUBI = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1111;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_IMEM_TO = 2'b10;
  localparam logic [1:0] ERR_DMEM_TO = 2'b11;

  localparam logic [7:0]       WAIT_MAX = 8'(MEM_TO);
  localparam logic [CNT_W-1:0] RET_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic       imm_src;
    logic [2:0] alu_op;
    logic       is_load;
    logic       is_store;
  } dec_t;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_ADD, OP_LW, OP_SW, OP_SUBI, OP_OR, OP_NOR: op_legal = 1'b1;
      default:                                     op_legal = 1'b0;
    endcase
  endfunction

  function automatic dec_t op_decode(input logic [3:0] op);
    dec_t d;
    d = '{imm_src: 1'b0, alu_op: 3'b010, is_load: 1'b0, is_store: 1'b0};
    case (op)
      OP_LW:   begin d.imm_src = 1'b1; d.is_load  = 1'b1; end
      OP_SW:   begin d.imm_src = 1'b1; d.is_store = 1'b1; end
      OP_SUBI: begin d.imm_src = 1'b1; d.alu_op   = 3'b110; end
      OP_OR:   d.alu_op = 3'b001;
      OP_NOR:  d.alu_op = 3'b011;
      default: ;
    endcase
    return d;
  endfunction

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [7:0]       wait_q, wait_d;
  logic [1:0]       err_q, err_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  dec_t             dec;

  assign dec = op_decode(op_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      op_q      <= 4'b0000;
      wait_q    <= 8'd0;
      err_q     <= ERR_NONE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      err_q     <= err_d;
      retired_q <= retired_d;
    end
  end

  // Next state. The wait counter restarts on every transition, so each wait
  // state gets its own full timeout window; ready at WAIT_MAX still succeeds.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    wait_d    = wait_q;
    err_d     = err_q;
    retired_d = retired_q;
    unique case (state_q)
      S_FETCH: begin
        if (!run) begin
          wait_d = 8'd0;
        end else if (imem_rdy) begin
          state_d = S_DECODE;
          wait_d  = 8'd0;
        end else if (wait_q == WAIT_MAX) begin
          state_d = S_HALT;
          err_d   = ERR_IMEM_TO;
          wait_d  = 8'd0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        op_d   = opcode;
        wait_d = 8'd0;
        if (op_legal(opcode)) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_HALT;
          err_d   = ERR_ILLEGAL;
        end
      end
      S_EXEC: begin
        wait_d  = 8'd0;
        state_d = (dec.is_load || dec.is_store) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (dmem_rdy) begin
          wait_d = 8'd0;
          if (dec.is_load) begin
            state_d = S_WB;
          end else begin
            state_d   = S_FETCH;
            retired_d = retired_q + RET_ONE;
          end
        end else if (wait_q == WAIT_MAX) begin
          state_d = S_HALT;
          err_d   = ERR_DMEM_TO;
          wait_d  = 8'd0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        state_d   = S_FETCH;
        wait_d    = 8'd0;
        retired_d = retired_q + RET_ONE;
      end
      S_HALT: ;
      default: begin
        state_d = S_FETCH;
        wait_d  = 8'd0;
      end
    endcase
  end

  // Datapath strobes. Only the FETCH handshake looks at live inputs; the ALU
  // controls stay on op_q from EXEC through MEM and WB so operands remain stable.
  always_comb begin
    imem_req = 1'b0;
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    EnRW     = 1'b0;
    ALUsrc   = 1'b0;
    ALUctrl  = 3'b010;
    MReg     = 1'b1;
    MR       = 1'b0;
    MW       = 1'b0;
    busy     = (state_q != S_FETCH);
    halted   = (state_q == S_HALT);
    err_code = err_q;
    retired  = retired_q;
    unique case (state_q)
      S_FETCH: begin
        imem_req = run;
        PCWrite  = run && imem_rdy;
        IRWrite  = run && imem_rdy;
      end
      S_EXEC: begin
        ALUsrc  = dec.imm_src;
        ALUctrl = dec.alu_op;
      end
      S_MEM: begin
        ALUsrc  = dec.imm_src;
        ALUctrl = dec.alu_op;
        MR      = dec.is_load;
        MW      = dec.is_store;
      end
      S_WB: begin
        ALUsrc  = dec.imm_src;
        ALUctrl = dec.alu_op;
        EnRW    = 1'b1;
        MReg    = !dec.is_load;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: an instruction-level model expands each
// instruction into its expected per-cycle strobe trace, compared cycle by cycle.
`timescale 1ns/1ps
module tb_multicycle_sequencer;
  localparam int MEM_TO = 3;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  logic rst, run, imem_rdy, dmem_rdy;
  logic [3:0] opcode;
  logic imem_req, PCWrite, IRWrite, EnRW, ALUsrc, MReg, MR, MW, busy, halted;
  logic [2:0] ALUctrl;
  logic [1:0] err_code;
  logic [CNT_W-1:0] retired;

  multicycle_sequencer #(.MEM_TO(MEM_TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode),
    .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy),
    .imem_req(imem_req), .PCWrite(PCWrite), .IRWrite(IRWrite), .EnRW(EnRW),
    .ALUsrc(ALUsrc), .ALUctrl(ALUctrl), .MReg(MReg), .MR(MR), .MW(MW),
    .busy(busy), .halted(halted), .err_code(err_code), .retired(retired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Output vector: req pcw irw enrw src ctl[2:0] mreg mr mw busy halted err[1:0]
  typedef logic [14:0] ov_t;
  localparam int B_REQ = 14, B_PCW = 13, B_IRW = 12, B_ENRW = 11, B_SRC = 10;
  localparam int B_MREG = 6, B_MR = 5, B_MW = 4, B_BUSY = 3, B_HALT = 2;
  localparam ov_t DEF = 15'b0000_0_010_1_0_0_0_0_00;

  typedef struct {
    logic       run, irdy, drdy;
    logic [3:0] opc;
    ov_t        exp;
    int         ret;
  } step_t;

  step_t plan[$];
  int    model_ret;

  function automatic ov_t obs();
    return {imem_req, PCWrite, IRWrite, EnRW, ALUsrc, ALUctrl, MReg, MR, MW,
            busy, halted, err_code};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] rop();
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic logic [3:0] rand_legal_op();
    case ($urandom_range(0, 5))
      0: return 4'h0;
      1: return 4'h1;
      2: return 4'h2;
      3: return 4'h3;
      4: return 4'h7;
      default: return 4'hF;
    endcase
  endfunction

  function automatic void op_info(input logic [3:0] op, output logic legal, output logic src,
                                  output logic [2:0] ctl, output logic ld, output logic st,
                                  output logic wb);
    legal = 1'b1; src = 1'b0; ctl = 3'b010; ld = 1'b0; st = 1'b0; wb = 1'b1;
    case (op)
      4'h0: ;
      4'h1: begin src = 1'b1; ld = 1'b1; end
      4'h2: begin src = 1'b1; st = 1'b1; wb = 1'b0; end
      4'h3: begin src = 1'b1; ctl = 3'b110; end
      4'h7: ctl = 3'b001;
      4'hF: ctl = 3'b011;
      default: begin legal = 1'b0; wb = 1'b0; end
    endcase
  endfunction

  task automatic push(input logic r, input logic ir, input logic dr, input logic [3:0] op,
                      input ov_t e);
    plan.push_back('{r, ir, dr, op, e, model_ret});
  endtask

  task automatic m_fwait(input int n);
    ov_t e;
    e = DEF; e[B_REQ] = 1'b1;
    for (int i = 0; i < n; i++) push(1'b1, 1'b0, rb(), rop(), e);
  endtask

  task automatic m_idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, rb(), rb(), rop(), DEF);
  endtask

  task automatic m_halt(input logic [1:0] err, input int n);
    ov_t e;
    e = DEF; e[B_BUSY] = 1'b1; e[B_HALT] = 1'b1; e[1:0] = err;
    for (int i = 0; i < n; i++) push(1'b1, rb(), rb(), rop(), e);
  endtask

  // fw/dw: not-ready cycles before imem/dmem ready; dto: data memory never answers.
  task automatic m_instr(input logic [3:0] op, input int fw, input int dw, input logic dto);
    logic legal, src, ld, st, wb;
    logic [2:0] ctl;
    ov_t e;
    op_info(op, legal, src, ctl, ld, st, wb);
    m_fwait(fw);
    e = DEF; e[B_REQ] = 1'b1; e[B_PCW] = 1'b1; e[B_IRW] = 1'b1;
    push(1'b1, 1'b1, rb(), rop(), e);
    e = DEF; e[B_BUSY] = 1'b1;
    push(rb(), rb(), rb(), op, e);
    if (!legal) begin
      m_halt(2'b01, 4);
      return;
    end
    e[B_SRC] = src; e[9:7] = ctl;
    push(rb(), rb(), rb(), rop(), e);
    if (ld || st) begin
      e[B_MR] = ld; e[B_MW] = st;
      if (dto) begin
        for (int j = 0; j <= MEM_TO; j++) push(rb(), rb(), 1'b0, rop(), e);
        m_halt(2'b11, 3);
        return;
      end
      for (int j = 0; j < dw; j++) push(rb(), rb(), 1'b0, rop(), e);
      push(rb(), rb(), 1'b1, rop(), e);
      if (st) model_ret++;
      e[B_MR] = 1'b0; e[B_MW] = 1'b0;
    end
    if (wb) begin
      e[B_ENRW] = 1'b1; e[B_MREG] = !ld;
      push(rb(), rb(), rb(), rop(), e);
      model_ret++;
    end
  endtask

  task automatic apply(input step_t s);
    @(posedge clk);
    #1;
    run = s.run; imem_rdy = s.irdy; dmem_rdy = s.drdy; opcode = s.opc;
    #3;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; imem_rdy = 1'b0; dmem_rdy = 1'b0; opcode = 4'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_ret = 0;
    plan.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 run = 1'b0; imem_rdy = rb(); dmem_rdy = rb(); opcode = rop();
      #3;
      checks++;
      if (obs() !== DEF) $display("FAIL reset_outputs got %h want %h", obs(), DEF);
      else passed++;
      checks++;
      if (retired !== '0) $display("FAIL reset_retired got %0d want 0", retired);
      else passed++;
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_add();
    do_reset();
    m_instr(4'h0, 0, 0, 1'b0);
    m_fwait(1);
    m_idle(1);
    foreach (plan[k]) begin
      apply(plan[k]);
      checks++;
      if (obs() !== plan[k].exp) $display("FAIL add step %0d got %h want %h", k, obs(), plan[k].exp);
      else passed++;
      checks++;
      if (retired !== CNT_W'(plan[k].ret)) $display("FAIL add_retired step %0d got %0d want %0d", k, retired, plan[k].ret);
      else passed++;
    end
  endtask

  task automatic test_lw();
    do_reset();
    m_instr(4'h1, 0, 2, 1'b0);
    m_idle(1);
    foreach (plan[k]) begin
      apply(plan[k]);
      checks++;
      if (obs() !== plan[k].exp) $display("FAIL lw step %0d got %h want %h", k, obs(), plan[k].exp);
      else passed++;
      checks++;
      if (retired !== CNT_W'(plan[k].ret)) $display("FAIL lw_retired step %0d got %0d want %0d", k, retired, plan[k].ret);
      else passed++;
    end
  endtask

  task automatic test_sw_subi();
    do_reset();
    m_instr(4'h2, 0, 3, 1'b0);
    m_instr(4'h3, 1, 0, 1'b0);
    m_idle(1);
    foreach (plan[k]) begin
      apply(plan[k]);
      checks++;
      if (obs() !== plan[k].exp) $display("FAIL sw_subi step %0d got %h want %h", k, obs(), plan[k].exp);
      else passed++;
      checks++;
      if (retired !== CNT_W'(plan[k].ret)) $display("FAIL sw_subi_retired step %0d got %0d want %0d", k, retired, plan[k].ret);
      else passed++;
    end
  endtask

  task automatic test_illegal();
    do_reset();
    m_instr(4'h7, 0, 0, 1'b0);
    m_instr(4'h5, 0, 0, 1'b0);
    foreach (plan[k]) begin
      apply(plan[k]);
      checks++;
      if (obs() !== plan[k].exp) $display("FAIL illegal step %0d got %h want %h", k, obs(), plan[k].exp);
      else passed++;
      checks++;
      if (retired !== CNT_W'(plan[k].ret)) $display("FAIL illegal_retired step %0d got %0d want %0d", k, retired, plan[k].ret);
      else passed++;
    end
  endtask

  task automatic test_timeouts();
    for (int sc = 0; sc < 3; sc++) begin
      do_reset();
      case (sc)
        0: begin m_instr(4'h1, MEM_TO, MEM_TO, 1'b0); m_instr(4'h2, MEM_TO, MEM_TO, 1'b0); m_idle(1); end
        1: m_instr(4'h1, 0, 0, 1'b1);
        default: begin m_fwait(MEM_TO + 1); m_halt(2'b10, 3); end
      endcase
      foreach (plan[k]) begin
        apply(plan[k]);
        checks++;
        if (obs() !== plan[k].exp) $display("FAIL timeout%0d step %0d got %h want %h", sc, k, obs(), plan[k].exp);
        else passed++;
        checks++;
        if (retired !== CNT_W'(plan[k].ret)) $display("FAIL timeout%0d_retired step %0d got %0d want %0d", sc, k, retired, plan[k].ret);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_in_mem();
    do_reset();
    m_instr(4'h0, 0, 0, 1'b0);
    m_instr(4'h2, 0, 2, 1'b0);
    void'(plan.pop_back());
    void'(plan.pop_back());
    foreach (plan[k]) begin
      apply(plan[k]);
      checks++;
      if (obs() !== plan[k].exp) $display("FAIL rst_mem step %0d got %h want %h", k, obs(), plan[k].exp);
      else passed++;
    end
    @(posedge clk);
    #1 run = 1'b1; dmem_rdy = 1'b0;
    #2;
    checks++;
    if (MW !== 1'b1) $display("FAIL rst_mem_mw_before got %b want 1", MW);
    else passed++;
    rst = 1'b1; run = 1'b0;
    #1;
    checks++;
    if (obs() !== DEF) $display("FAIL rst_mem_outputs got %h want %h", obs(), DEF);
    else passed++;
    checks++;
    if (retired !== '0) $display("FAIL rst_mem_retired got %0d want 0", retired);
    else passed++;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_run_idle();
    do_reset();
    m_idle(10);
    m_fwait(2);
    m_idle(3);
    m_instr(4'hF, MEM_TO, 0, 1'b0);
    m_idle(1);
    foreach (plan[k]) begin
      apply(plan[k]);
      checks++;
      if (obs() !== plan[k].exp) $display("FAIL run_idle step %0d got %h want %h", k, obs(), plan[k].exp);
      else passed++;
      checks++;
      if (retired !== CNT_W'(plan[k].ret)) $display("FAIL run_idle_retired step %0d got %0d want %0d", k, retired, plan[k].ret);
      else passed++;
    end
  endtask

  task automatic test_back_to_back_random();
    do_reset();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) m_idle($urandom_range(1, 2));
      m_instr(rand_legal_op(), $urandom_range(0, MEM_TO), $urandom_range(0, MEM_TO), 1'b0);
    end
    m_idle(1);
    foreach (plan[k]) begin
      apply(plan[k]);
      checks++;
      if (obs() !== plan[k].exp) $display("FAIL random step %0d got %h want %h", k, obs(), plan[k].exp);
      else passed++;
      checks++;
      if (retired !== CNT_W'(plan[k].ret)) $display("FAIL random_retired step %0d got %0d want %0d", k, retired, plan[k].ret);
      else passed++;
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; imem_rdy = 1'b0; dmem_rdy = 1'b0; opcode = 4'h0;
    model_ret = 0;
    test_reset();
    test_add();
    test_lw();
    test_sw_subi();
    test_illegal();
    test_timeouts();
    test_reset_in_mem();
    test_run_idle();
    test_back_to_back_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
